// File: rtl/game_pkg.sv
// Shared mode encodings and helpers for the game sequencer and its timeout stage.
package game_pkg;

  localparam int unsigned FACE_W = 4;
  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_INTRO   = 3'b000,
    MODE_SELECT  = 3'b001,
    MODE_REVEAL  = 3'b010,
    MODE_JUDGE   = 3'b011,
    MODE_WIN     = 3'b100,
    MODE_MATCH   = 3'b101,
    MODE_MISS    = 3'b110,
    MODE_ILLEGAL = 3'b111
  } mode_e;

  // Modes during which the timeout stage runs and may raise C.
  function automatic logic is_timed(input mode_e m);
    return (m == MODE_INTRO) || (m == MODE_REVEAL) ||
           (m == MODE_MATCH) || (m == MODE_MISS);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an asynchronous button, followed by a rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse_c = r_sync2 & ~r_prev;

endmodule

// File: rtl/game_mode_fsm.sv
// Chicken Cha-Cha-Cha game sequencer: mode bus, turn and position tracking, card/tile judge.
module game_mode_fsm
  import game_pkg::*;
#(
  parameter int unsigned TRACK_LEN = 16,
  parameter int unsigned POS_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_pick,
  input  logic [3:0]        card_face,
  input  logic [3:0]        tile_face,
  input  logic              C,
  output logic [2:0]        M,
  output logic              player,
  output logic [POS_W-1:0]  pos0,
  output logic [POS_W-1:0]  pos1,
  output logic [POS_W-1:0]  tile_addr,
  output logic              winner
);

  localparam int unsigned GOAL = TRACK_LEN - 1;
  localparam int unsigned AW   = POS_W + 1;

  mode_e              r_mode;
  logic               r_player;
  logic [POS_W-1:0]   r_pos0;
  logic [POS_W-1:0]   r_pos1;
  logic               r_winner;
  logic [FACE_W-1:0]  r_card;
  logic               r_c_q;

  logic               w_start;
  logic               w_pick;
  logic               w_to;
  logic [POS_W-1:0]   w_pos_cur;
  logic [POS_W-1:0]   w_pos_oth;
  logic [AW-1:0]      w_n1;
  logic [AW-1:0]      w_n2;
  logic [AW-1:0]      w_n;

  btn_edge u_start (.clk(clk), .rst(rst), .i_btn(btn_start), .o_pulse_c(w_start));
  btn_edge u_pick  (.clk(clk), .rst(rst), .i_btn(btn_pick),  .o_pulse_c(w_pick));

  // C is a level held until M leaves the timed set; only its rising edge counts.
  assign w_to = C & ~r_c_q & is_timed(r_mode);

  // Next tile: one ahead, hop over the opponent, never past the goal (extra bit avoids wrap).
  assign w_pos_cur = r_player ? r_pos1 : r_pos0;
  assign w_pos_oth = r_player ? r_pos0 : r_pos1;
  assign w_n1      = AW'(w_pos_cur) + AW'(1);
  assign w_n2      = (w_n1 == AW'(w_pos_oth)) ? (w_n1 + AW'(1)) : w_n1;
  assign w_n       = (w_n2 > AW'(GOAL)) ? AW'(GOAL) : w_n2;
  assign tile_addr = POS_W'(w_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= MODE_INTRO;
      r_player <= 1'b0;
      r_pos0   <= '0;
      r_pos1   <= '0;
      r_winner <= 1'b0;
      r_card   <= '0;
      r_c_q    <= 1'b0;
    end else begin
      r_c_q <= C;
      case (r_mode)
        MODE_INTRO:  if (w_to) r_mode <= MODE_SELECT;
        MODE_SELECT: if (w_pick) begin
          r_card <= card_face;
          r_mode <= MODE_REVEAL;
        end
        MODE_REVEAL: if (w_to) r_mode <= MODE_JUDGE;
        MODE_JUDGE: begin
          if (r_card == tile_face) begin
            if (r_player) r_pos1 <= tile_addr;
            else          r_pos0 <= tile_addr;
            r_mode <= MODE_MATCH;
          end else begin
            r_mode <= MODE_MISS;
          end
        end
        MODE_MATCH: if (w_to) begin
          if (w_pos_cur == POS_W'(GOAL)) begin
            r_winner <= r_player;
            r_mode   <= MODE_WIN;
          end else begin
            r_mode <= MODE_SELECT;
          end
        end
        MODE_MISS: if (w_to) begin
          r_player <= ~r_player;
          r_mode   <= MODE_SELECT;
        end
        MODE_WIN: if (w_start) begin
          r_pos0   <= '0;
          r_pos1   <= '0;
          r_player <= 1'b0;
          r_winner <= 1'b0;
          r_mode   <= MODE_INTRO;
        end
        default: r_mode <= MODE_INTRO;
      endcase
    end
  end

  assign M      = r_mode;
  assign player = r_player;
  assign pos0   = r_pos0;
  assign pos1   = r_pos1;
  assign winner = r_winner;

endmodule

// File: doc/game_mode_fsm.md
# game_mode_fsm

Top-level game sequencer for the Chicken Cha-Cha-Cha board. It produces the 3-bit mode bus `M` that drives the timeout counter stage, and consumes that stage's `C` flag as its "timed phase elapsed" event. It also tracks whose turn it is and each player's track position, and judges card-versus-tile matches. It sits between the debounced player buttons / card and tile ROMs and the timer and display stages.

## Interface
- `TRACK_LEN`, default 16: number of track tiles. The goal tile is `GOAL = TRACK_LEN-1`.
- `POS_W`, default 4: position width; must satisfy `2**POS_W >= TRACK_LEN`.
- `clk`, input, 1: system clock; the block has one clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `btn_start`, input, 1: debounced start button, asynchronous to `clk`.
- `btn_pick`, input, 1: debounced "card picked" button, asynchronous to `clk`.
- `card_face`, input, 4: face value of the currently selected card (combinational from the card ROM).
- `tile_face`, input, 4: face value of tile `tile_addr` (combinational from the track ROM).
- `C`, input, 1: timed-phase flag from the timeout stage.
- `M`, output, 3: current mode (registered).
- `player`, output, 1: current player, 0 or 1.
- `pos0`, `pos1`, output, POS_W: player positions.
- `tile_addr`, output, POS_W: target tile for the current player.
- `winner`, output, 1: valid in WIN mode.

## Operation
- Mode encoding:
  - Timed modes: INTRO=000, REVEAL=010, MATCH=101, MISS=110.
  - Untimed modes: SELECT=001, JUDGE=011, WIN=100.
  - 111 is illegal and goes to INTRO on the next cycle.
- Timeout event: `to = C & ~c_q`, where `c_q` is `C` registered.
  - `C` is a level that stays high until `M` leaves the timed set, so only its rising edge counts.
  - Every timed mode exits only into an untimed mode, which guarantees `C` returns low between timed phases.
- Buttons pass through a 2-flop synchronizer, then rising-edge detection. This yields one-cycle pulses `start_p` and `pick_p`.
- Transitions:
  - INTRO: on `to`, go to SELECT.
  - SELECT: on `pick_p`, latch `card_q <= card_face` and go to REVEAL.
  - REVEAL: on `to`, go to JUDGE.
  - JUDGE: always exactly one cycle. If `card_q == tile_face`, set `pos[player] <= tile_addr` and go to MATCH. Otherwise go to MISS.
  - MATCH: on `to`, go to WIN with `winner <= player` if `pos[player] == GOAL`. Otherwise go to SELECT, with the same player continuing.
  - MISS: on `to`, set `player <= ~player` and go to SELECT.
  - WIN: on `start_p`, go to INTRO and clear `pos0`, `pos1`, `player` and `winner` to 0.
- `tile_addr` is computed combinationally from registered state:
  - Let `n = pos[player]+1`.
  - If `pos[~player] == n`, then `n = n+1` (skip an occupied tile).
  - Clamp `n` to GOAL.
  - Width is `POS_W+1` internally, so there is no wrap. A player at GOAL never requests beyond GOAL.
- Ignored pulses:
  - `start_p` is ignored outside WIN.
  - `pick_p` is ignored outside SELECT.
  - `to` is ignored in untimed modes.

## Timing
- Reset values: `M`=000 (INTRO), `player`=0, `pos0`=`pos1`=0, `winner`=0, `card_q`=0, `c_q`=0, and all synchronizer flops 0.
- `rst` asserted mid-game returns the block to INTRO immediately. The timeout stage resets on the same `rst`, so no stale `C` survives.
- Button latency: raw edge, then 2 sync cycles, then a `start_p`/`pick_p` pulse, then `M` changes on the next edge. This is 3 cycles from the raw edge to `M`.
- Timeout latency: `C` rises in cycle t, `to` is seen in cycle t, and `M` changes at the edge ending t.
- The timeout stage clears `C` at the first edge where it sees an untimed `M`. JUDGE's single cycle is therefore sufficient before MATCH or MISS.
- `tile_addr` must be stable from SELECT through JUDGE, because positions change only when leaving JUDGE or WIN.
- Simultaneous `pick_p` and `start_p` in SELECT: only `pick_p` acts.

## Structure
- Shared package `game_pkg`: holds the mode encodings (`MODE_INTRO`…`MODE_MISS`), the timed-mode predicate, and the face width (4). The timeout stage must use the same package constants.
- Sub-module `btn_edge`: 2-flop synchronizer plus rising-edge pulse, async reset, instanced twice.
- The main block holds the mode register, player and position registers, `card_q`, and the judge compare.

## Test plan
- Reset to INTRO, then pulse `C` high: `M` goes 000→001. With `C` held high for 5 further cycles, there are no further transitions.
- SELECT with `card_face`=5, pick, `card_face` changed to 9, then `to`; at JUDGE `tile_face`=5 → `M`=101 and `pos0`=1. After `to`, `M`=001 and `player` is still 0.
- Mismatch in JUDGE (`card_q`=3, `tile_face`=7) → `M`=110, positions unchanged. After `to`, `player`=1 and `M`=001.
- Skip rule: `pos0`=4, `pos1`=5, `player`=0 → `tile_addr`=6. `pos0`=14, `pos1`=15 → `tile_addr`=15 (clamped).
- Player 1 at 14 matches onto 15 → MATCH. After `to`, `M`=100 and `winner`=1. `pick_p` is ignored. `start_p` → `M`=000 with both positions 0.
- Force `M`=111 via a state poke → INTRO the next cycle. Assert `rst` during REVEAL → all outputs at reset values within the same cycle (asynchronous).
